// File: rtl/timer_tick_logger.sv
// timer_tick_logger: timestamps rising edges of tick_in into a FIFO that software drains
// over a 16-bit Avalon-MM slave, with a level-threshold interrupt.
module timer_tick_logger #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] writedata,
    input  logic        tick_in,
    output logic [15:0] readdata,
    output logic        irq
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);
    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    logic [31:0] cyc_q, ticks_q, snap_q, snap_d, head;
    logic [31:0] mem_q [DEPTH];
    logic [7:0]  ctrl_q, ctrl_d;
    logic [4:0]  level_q, level_d;
    ptr_t        rd_ptr_q, wr_ptr_q;
    logic        tick_q, ovf_q, ovf_d, irq_q, irq_d;
    logic [15:0] readdata_q, readdata_d;
    logic        wr_en, rd_en, tick_ev, empty, full, pop, push, drop;
    logic        unused_hi;

    assign unused_hi = ^writedata[15:8];

    always_comb begin
        wr_en   = chipselect & ~write_n;
        rd_en   = chipselect & ~read_n;
        tick_ev = tick_in & ~tick_q & ctrl_q[0];
        empty   = level_q == 5'd0;
        full    = level_q == DEPTH_L;
        head    = mem_q[rd_ptr_q];
        pop     = rd_en & (address == 3'd3) & ~empty;
        // a pop frees the slot, so a full FIFO still accepts a simultaneous push
        push    = tick_ev & (~full | pop);
        drop    = tick_ev & full & ~pop;
        level_d = level_q + {4'd0, push} - {4'd0, pop};
        ovf_d   = drop | (ovf_q & ~(wr_en & (address == 3'd0)));
        ctrl_d  = (wr_en & (address == 3'd1)) ? writedata[7:0] : ctrl_q;
        snap_d  = (wr_en & ((address == 3'd4) | (address == 3'd5))) ? ticks_q : snap_q;
        irq_d   = ctrl_q[1] & (ctrl_q[7:4] != 4'd0) & (level_d >= {1'b0, ctrl_q[7:4]});
        readdata_d = '0;
        case (address)
            3'd0: readdata_d = {7'd0, level_q, 1'b0, ovf_q, full, empty};
            3'd1: readdata_d = {8'd0, ctrl_q};
            3'd2: readdata_d = empty ? 16'd0 : head[15:0];
            3'd3: readdata_d = empty ? 16'd0 : head[31:16];
            3'd4: readdata_d = snap_q[15:0];
            3'd5: readdata_d = snap_q[31:16];
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q      <= '0;
            ticks_q    <= '0;
            snap_q     <= '0;
            ctrl_q     <= '0;
            level_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tick_q     <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            cyc_q      <= cyc_q + 32'd1;
            ticks_q    <= ticks_q + {31'd0, tick_ev};
            snap_q     <= snap_d;
            ctrl_q     <= ctrl_d;
            level_q    <= level_d;
            rd_ptr_q   <= pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
            wr_ptr_q   <= push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
            tick_q     <= tick_in;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    // storage needs no reset: empty entries are never visible on the bus
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cyc_q;
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_timer_tick_logger.sv
// tb_timer_tick_logger: vector table, directed corner sequences and random traffic
// checked against a queue-based model of the logger.
module tb_timer_tick_logger;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic        tick_in = 1'b0;
    logic [15:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_q[$];
    logic [31:0] m_cyc, m_ticks, m_snap;
    logic [7:0]  m_ctrl;
    logic        m_ovf, m_tickd, m_irq;
    logic [15:0] m_rd;
    logic [31:0] ts [10];

    typedef struct {
        logic [2:0]  a;
        bit          w;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;
    vec_t tv [14];

    timer_tick_logger #(.DEPTH_LOG2(3)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .tick_in(tick_in),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [15:0] v;
        logic [31:0] h;
        bit ev, pop, set_ovf;
        int n;
        n = m_q.size();
        h = (n > 0) ? m_q[0] : 32'd0;
        case (address)
            3'd0: v = {7'd0, 5'(n), 1'b0, m_ovf, n == DEPTH, n == 0};
            3'd1: v = {8'd0, m_ctrl};
            3'd2: v = h[15:0];
            3'd3: v = h[31:16];
            3'd4: v = m_snap[15:0];
            3'd5: v = m_snap[31:16];
            default: v = 16'd0;
        endcase
        ev = tick_in && !m_tickd && m_ctrl[0];
        pop = chipselect && !read_n && address == 3'd3 && n > 0;
        set_ovf = 0;
        if (pop) void'(m_q.pop_front());
        if (ev) begin
            if (n < DEPTH || pop) m_q.push_back(m_cyc);
            else set_ovf = 1;
        end
        m_irq = m_ctrl[1] && m_ctrl[7:4] != 0 && m_q.size() >= int'(m_ctrl[7:4]);
        if (chipselect && !write_n) begin
            if (address == 3'd0) m_ovf = 0;
            if (address == 3'd1) m_ctrl = writedata[7:0];
            if (address == 3'd4 || address == 3'd5) m_snap = m_ticks;
        end
        if (set_ovf) m_ovf = 1;
        if (ev) m_ticks++;
        m_cyc++;
        m_tickd = tick_in;
        m_rd = v;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("readdata_vs_model", 32'(readdata), 32'(m_rd));
        chk("irq_vs_model", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle();
        chipselect = 0; read_n = 1; write_n = 1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string nm);
        address = a; chipselect = 1; read_n = 0; write_n = 1;
        step();
        chk(nm, 32'(readdata), 32'(exp));
        idle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1; read_n = 1; write_n = 0;
        step();
        idle();
    endtask

    task automatic pulse(input int k);
        ts[k] = m_cyc;
        tick_in = 1; step();
        tick_in = 0; step();
    endtask

    task automatic do_reset();
        idle();
        tick_in = 0;
        reset_n = 0;
        #2;
        chk("async_reset_readdata", 32'(readdata), 32'd0);
        chk("async_reset_irq", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1;
        m_q.delete();
        m_cyc = 0; m_ticks = 0; m_snap = 0; m_ctrl = 0;
        m_ovf = 0; m_tickd = 0; m_irq = 0; m_rd = 0;
    endtask

    initial begin
        tv[0]  = '{3'd0, 1'b0, 16'h0000, 16'h0001};
        tv[1]  = '{3'd1, 1'b0, 16'h0000, 16'h0000};
        tv[2]  = '{3'd2, 1'b0, 16'h0000, 16'h0000};
        tv[3]  = '{3'd3, 1'b0, 16'h0000, 16'h0000};
        tv[4]  = '{3'd4, 1'b0, 16'h0000, 16'h0000};
        tv[5]  = '{3'd5, 1'b0, 16'h0000, 16'h0000};
        tv[6]  = '{3'd6, 1'b0, 16'h0000, 16'h0000};
        tv[7]  = '{3'd1, 1'b1, 16'h00A5, 16'h0000};
        tv[8]  = '{3'd1, 1'b0, 16'h0000, 16'h00A5};
        tv[9]  = '{3'd1, 1'b1, 16'hFF21, 16'h00A5};
        tv[10] = '{3'd1, 1'b0, 16'h0000, 16'h0021};
        tv[11] = '{3'd6, 1'b1, 16'hFFFF, 16'h0000};
        tv[12] = '{3'd7, 1'b1, 16'h1234, 16'h0000};
        tv[13] = '{3'd0, 1'b0, 16'h0000, 16'h0001};

        #1;
        do_reset();
        chk("reset_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 14; i++) begin
            address = tv[i].a; writedata = tv[i].d; chipselect = 1;
            read_n = tv[i].w; write_n = !tv[i].w;
            step();
            chk($sformatf("vec%0d", i), 32'(readdata), 32'(tv[i].exp));
            idle();
        end

        // timestamps at cycle counter 100 and 250, ticks held several cycles
        do_reset();
        wr(1, 16'h0021);
        while (m_cyc != 100) step();
        tick_in = 1; repeat (4) step();
        tick_in = 0;
        while (m_cyc != 250) step();
        tick_in = 1; repeat (4) step();
        tick_in = 0; step();
        rd(0, 16'h0020, "status_level2");
        rd(2, 16'd100, "ts0_lo");
        rd(3, 16'd0, "ts0_hi");
        rd(2, 16'd250, "ts1_lo");
        rd(3, 16'd0, "ts1_hi");
        rd(0, 16'h0001, "status_drained");

        // overflow on ninth tick, first eight retained
        do_reset();
        wr(1, 16'h0001);
        for (int i = 0; i < 9; i++) pulse(i);
        rd(0, 16'h0086, "status_ovf");
        wr(0, 16'h0000);
        rd(0, 16'h0082, "status_ovf_clr");
        for (int i = 0; i < 8; i++) begin
            rd(2, ts[i][15:0], $sformatf("ovf_ts%0d_lo", i));
            rd(3, ts[i][31:16], $sformatf("ovf_ts%0d_hi", i));
        end
        rd(0, 16'h0001, "status_empty");

        // irq threshold 2, then async reset while irq is high
        do_reset();
        wr(1, 16'h0023);
        tick_in = 1; step();
        chk("irq_after_t1", 32'(irq), 32'd0);
        tick_in = 0; step();
        tick_in = 1; step();
        chk("irq_after_t2", 32'(irq), 32'd1);
        tick_in = 0; step();
        rd(3, 16'd0, "irq_pop");
        chk("irq_after_pop", 32'(irq), 32'd0);
        pulse(0);
        rd(0, 16'h0020, "irq_level2");
        chk("irq_relevel", 32'(irq), 32'd1);
        do_reset();
        rd(0, 16'h0001, "after_midreset");

        // push and pop in the same cycle while full
        do_reset();
        wr(1, 16'h0001);
        for (int i = 0; i < 8; i++) pulse(i);
        rd(0, 16'h0082, "full_status");
        ts[8] = m_cyc;
        tick_in = 1; address = 3; chipselect = 1; read_n = 0;
        step();
        chk("simul_pop_data", 32'(readdata), 32'(ts[0][31:16]));
        idle(); tick_in = 0; step();
        rd(0, 16'h0082, "simul_status");
        for (int i = 1; i < 9; i++) begin
            rd(2, ts[i][15:0], $sformatf("simul_ts%0d_lo", i));
            rd(3, ts[i][31:16], $sformatf("simul_ts%0d_hi", i));
        end

        // tick counter ignores disabled ticks; FIFO not flushed by disable
        do_reset();
        wr(1, 16'h0001);
        for (int i = 0; i < 5; i++) pulse(i);
        wr(1, 16'h0000);
        for (int i = 0; i < 3; i++) pulse(i);
        wr(4, 16'h0000);
        rd(4, 16'd5, "tick_lo");
        rd(5, 16'd0, "tick_hi");
        rd(0, 16'h0050, "no_flush");

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            address = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            read_n = 1'($urandom_range(0, 1));
            write_n = ($urandom_range(0, 3) != 0);
            writedata = 16'($urandom);
            if (address == 3'd1 && $urandom_range(0, 3) != 0) writedata[0] = 1'b1;
            tick_in = ($urandom_range(0, 2) == 0);
            step();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
